// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver: cycles a one-hot digit select over the
// captured hex value, with optional leading-zero blanking and frame-based blink.
module seg_scan_driver #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    input  logic                  blink_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0]         pre;
    logic [IW-1:0]         idx;
    logic [FW-1:0]         fcnt;
    logic                  phase;
    logic                  wrap_q;
    logic [4*DIGITS-1:0]   value_q;
    logic [DIGITS-1:0]     dp_q;

    logic                  tc;
    logic                  last;
    logic                  wrap;
    logic [3:0]            nib;
    logic                  upper_zero;
    logic [6:0]            seg_p0;
    logic                  dp_p0;
    logic [DIGITS-1:0]     an_p0;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign tc   = (pre == CW'(SCAN_DIV - 1));
    assign last = (idx == IW'(DIGITS - 1));
    assign wrap = tc && last;

    // Scan timing state: prescaler, digit index, blink frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre    <= '0;
            idx    <= '0;
            fcnt   <= '0;
            phase  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            pre    <= tc ? '0 : pre + 1'b1;
            wrap_q <= wrap;
            if (tc)
                idx <= last ? '0 : idx + 1'b1;
            if (!blink_en) begin
                fcnt  <= '0;
                phase <= 1'b0;
            end else if (wrap) begin
                if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            dp_q    <= '0;
        end else if (load) begin
            value_q <= value;
            dp_q    <= dp_in;
        end
    end

    // Stage p0: decode the currently selected digit
    always_comb begin
        nib        = value_q[4*int'(idx) +: 4];
        upper_zero = ((value_q >> {idx, 2'b00}) == '0);
        seg_p0     = (blank_lz && (idx != '0) && upper_zero) ? 7'h00 : hex7(nib);
        dp_p0      = dp_q[idx];
        an_p0      = (blink_en && phase) ? '0 : (DIGITS'(1) << idx);
    end

    // Stage p1: registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg        <= '0;
            dp         <= 1'b0;
            an         <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_p0;
            dp         <= dp_p0;
            an         <= an_p0;
            frame_done <= wrap_q;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver against a tick-count based
// reference model (4-digit instance plus a single-digit instance).
module tb_seg_scan_driver;

    localparam int DG = 4;
    localparam int SD = 4;
    localparam int BF = 2;
    localparam int SD1 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0] dp_in = '0;
    logic blank_lz = 1'b0;
    logic blink_en = 1'b0;
    logic [6:0] seg;
    logic dp;
    logic [3:0] an;
    logic frame_done;
    logic [6:0] seg1;
    logic dp1;
    logic [0:0] an1;
    logic frame_done1;

    int total = 0;
    int bad = 0;

    // reference model state
    int t = 0;
    int nw = 0;
    logic [15:0] vq = '0;
    logic [3:0] dq = '0;
    logic [6:0] e_seg, e_seg1;
    logic e_dp, e_fd, e_dp1, e_fd1;
    logic [3:0] e_an;

    logic [6:0] enc [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seg_scan_driver #(.DIGITS(DG), .SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .blink_en(blink_en), .seg(seg), .dp(dp), .an(an),
        .frame_done(frame_done)
    );

    seg_scan_driver #(.DIGITS(1), .SCAN_DIV(SD1), .BLINK_FRAMES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value[3:0]), .dp_in(dp_in[0:0]),
        .blank_lz(blank_lz), .blink_en(1'b0), .seg(seg1), .dp(dp1), .an(an1),
        .frame_done(frame_done1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0; nw = 0; vq = '0; dq = '0;
    endtask

    // One clock edge: predict registered outputs from pre-edge model state, then advance.
    task automatic tick();
        int d;
        logic [15:0] up;
        @(posedge clk);
        d = (t / SD) % DG;
        up = vq >> (4 * d);
        e_seg = (blank_lz && d > 0 && up == 16'h0) ? 7'h00 : enc[up[3:0]];
        e_dp = dq[d];
        e_an = (blink_en && ((nw / BF) % 2 == 1)) ? 4'b0000 : 4'(1 << d);
        e_fd = (t > 0) && (t % (SD * DG) == 0);
        e_seg1 = enc[vq[3:0]];
        e_dp1 = dq[0];
        e_fd1 = (t > 0) && (t % SD1 == 0);
        if (!blink_en) nw = 0;
        else if (t % (SD * DG) == SD * DG - 1) nw++;
        if (load) begin
            vq = value;
            dq = dp_in;
        end
        t++;
        #1;
        check_val("seg", 32'(seg), 32'(e_seg));
        check_val("dp", 32'(dp), 32'(e_dp));
        check_val("an", 32'(an), 32'(e_an));
        check_val("frame_done", 32'(frame_done), 32'(e_fd));
        check_val("seg1", 32'(seg1), 32'(e_seg1));
        check_val("dp1", 32'(dp1), 32'(e_dp1));
        check_val("an1", 32'(an1), 32'd1);
        check_val("frame_done1", 32'(frame_done1), 32'(e_fd1));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic load_val(input logic [15:0] v, input logic [3:0] d);
        value = v; dp_in = d; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_seg"}, 32'(seg), 32'd0);
        check_val({tag, "_dp"}, 32'(dp), 32'd0);
        check_val({tag, "_an"}, 32'(an), 32'd0);
        check_val({tag, "_fd"}, 32'(frame_done), 32'd0);
        check_val({tag, "_an1"}, 32'(an1), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        tick();
        check_val("post_rst_an", 32'(an), 32'h1);
        check_val("post_rst_seg", 32'(seg), 32'h3F);
    endtask

    // Advance until the next edge is the one where pre-edge tick count mod frame equals target.
    task automatic align_to(input int target);
        int guard = 0;
        while ((t % (SD * DG)) != target && guard < 64) begin
            tick();
            guard++;
        end
        check_val("align", 32'(t % (SD * DG)), 32'(target));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        release_reset();

        // Scan of a fixed value with one decimal point
        load_val(16'h1234, 4'b0010);
        run(40);

        foreach (enc[i]) begin
        end
        load_val(16'h3210, 4'b0001); run(16);
        load_val(16'h7654, 4'b0100); run(16);
        load_val(16'hBA98, 4'b1000); run(16);
        load_val(16'hFEDC, 4'b1111); run(16);

        blank_lz = 1'b1;
        load_val(16'h0050, 4'b0000); run(20);
        load_val(16'h0000, 4'b0000); run(20);
        blank_lz = 1'b0;

        blink_en = 1'b1;
        run(8 * SD * DG);
        blink_en = 1'b0;
        run(6);

        // Load landing on the terminal count of digit 0
        align_to(SD - 1);
        load_val(16'hAAAA, 4'b0000);
        tick();
        check_val("tc_load_an", 32'(an), 32'h2);
        check_val("tc_load_seg", 32'(seg), 32'h77);

        // Asynchronous reset while digit 2 is displayed
        load_val(16'h5678, 4'b0101);
        align_to(2 * SD + 1);
        tick();
        check_val("mid_an", 32'(an), 32'h4);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        release_reset();

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            load = ($urandom_range(0, 7) == 0);
            value = 16'($urandom());
            dp_in = 4'($urandom());
            if ($urandom_range(0, 40) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 60) == 0) blink_en = ~blink_en;
            tick();
        end
        load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
